// File: rtl/ex_mem_pkg.sv
// Shared constants, types and stall decode for the EX/MEM pipeline register.
// No logic of its own; sizes and encodings are fixed here.
// Stall decode is a pure function so every pipeline register decodes identically.
package ex_mem_pkg;

  localparam int DATA_W    = 32;
  localparam int REGADDR_W = 5;
  localparam int STALL_W   = 6;
  localparam int CNT_W     = 2;

  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  localparam logic                 RST_ACTIVE = 1'b0;
  localparam logic [DATA_W-1:0]    ZEROWORD   = '0;
  localparam logic [REGADDR_W-1:0] NOPREGADDR = '0;

  // Everything the memory stage receives from execute, as one word.
  typedef struct packed {
    logic [REGADDR_W-1:0] wd;
    logic                 wreg;
    logic [DATA_W-1:0]    wdata;
    logic                 whilo;
    logic [DATA_W-1:0]    hi;
    logic [DATA_W-1:0]    lo;
  } mem_bus_t;

  // What a pipeline register does on the coming edge.
  typedef enum logic [1:0] {
    OP_FLUSH   = 2'd0,
    OP_BUBBLE  = 2'd1,
    OP_ADVANCE = 2'd2,
    OP_HOLD    = 2'd3
  } pipe_op_t;

  // Flush beats everything; an unstalled upstream stage always advances,
  // even when the downstream stage claims to be stalled.
  function automatic pipe_op_t pipe_decode(input logic flush,
                                           input logic stall_cur,
                                           input logic stall_next);
    pipe_op_t op;
    if (flush)                      op = OP_FLUSH;
    else if (!stall_cur)            op = OP_ADVANCE;
    else if (!stall_next)           op = OP_BUBBLE;
    else                            op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/ex_mem_if.sv
// Bundle of controller, execute-side and memory-side signals around EX/MEM.
// Pure wiring; no latency.
// master drives stall/flush and the execute results; slave is the register.
interface ex_mem_if;
  import ex_mem_pkg::*;

  logic [STALL_W-1:0]   stall;
  logic                 flush;

  logic [REGADDR_W-1:0] ex_wd;
  logic                 ex_wreg;
  logic [DATA_W-1:0]    ex_wdata;
  logic                 ex_whilo;
  logic [DATA_W-1:0]    ex_hi;
  logic [DATA_W-1:0]    ex_lo;
  logic [2*DATA_W-1:0]  hilo_i;
  logic [CNT_W-1:0]     cnt_i;

  logic [REGADDR_W-1:0] mem_wd;
  logic                 mem_wreg;
  logic [DATA_W-1:0]    mem_wdata;
  logic                 mem_whilo;
  logic [DATA_W-1:0]    mem_hi;
  logic [DATA_W-1:0]    mem_lo;
  logic [2*DATA_W-1:0]  hilo_o;
  logic [CNT_W-1:0]     cnt_o;

  modport master (
    output stall, flush,
    output ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o
  );

  modport slave (
    input  stall, flush,
    input  ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o
  );

endinterface

// File: rtl/ex_mem_pipe_ctl_reg.sv
// Generic pipeline register with flush / bubble / advance / hold decode.
// Latency: one clock from d_i to q_o; reset and flush value is all-zero.
// Holds when both its own and the downstream stage are stalled.
module ex_mem_pipe_ctl_reg
  import ex_mem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         stall_cur_i,
  input  logic         stall_next_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  pipe_op_t     op;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  assign op = pipe_decode(flush_i, stall_cur_i, stall_next_i);

  // Next value: flush and bubble both load the NOP (all-zero) word.
  always_comb begin
    data_d = data_q;
    unique case (op)
      OP_FLUSH:   data_d = '0;
      OP_BUBBLE:  data_d = '0;
      OP_ADVANCE: data_d = d_i;
      OP_HOLD:    data_d = data_q;
    endcase
  end

  // State register; reset drops in-flight data at once.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register plus the MADD/MSUB accumulator kept across stalls.
// Latency: one clock from ex_* to mem_*; hilo_o/cnt_o loop back next cycle.
// Stall[3]/stall[4] select bubble or hold; flush clears everything.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  ex_mem_if.slave  bus
);

  mem_bus_t ex_dat;
  mem_bus_t mem_dat;
  pipe_op_t op;

  logic [2*DATA_W-1:0] hilo_q;
  logic [2*DATA_W-1:0] hilo_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;

  assign ex_dat.wd    = bus.ex_wd;
  assign ex_dat.wreg  = bus.ex_wreg;
  assign ex_dat.wdata = bus.ex_wdata;
  assign ex_dat.whilo = bus.ex_whilo;
  assign ex_dat.hi    = bus.ex_hi;
  assign ex_dat.lo    = bus.ex_lo;

  ex_mem_pipe_ctl_reg #(
    .W ($bits(mem_bus_t))
  ) u_pipe_reg (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (bus.flush),
    .stall_cur_i  (bus.stall[STALL_EX]),
    .stall_next_i (bus.stall[STALL_MEM]),
    .d_i          (ex_dat),
    .q_o          (mem_dat)
  );

  assign bus.mem_wd    = mem_dat.wd;
  assign bus.mem_wreg  = mem_dat.wreg;
  assign bus.mem_wdata = mem_dat.wdata;
  assign bus.mem_whilo = mem_dat.whilo;
  assign bus.mem_hi    = mem_dat.hi;
  assign bus.mem_lo    = mem_dat.lo;

  assign op = pipe_decode(bus.flush, bus.stall[STALL_EX], bus.stall[STALL_MEM]);

  // Accumulator only carries forward while execute sits in a bubble;
  // once the instruction leaves execute the partial state is discarded.
  always_comb begin
    hilo_d = hilo_q;
    cnt_d  = cnt_q;
    unique case (op)
      OP_FLUSH: begin
        hilo_d = '0;
        cnt_d  = '0;
      end
      OP_BUBBLE: begin
        hilo_d = bus.hilo_i;
        cnt_d  = bus.cnt_i;
      end
      OP_ADVANCE: begin
        hilo_d = '0;
        cnt_d  = '0;
      end
      OP_HOLD: begin
        hilo_d = hilo_q;
        cnt_d  = cnt_q;
      end
    endcase
  end

  // Accumulator registers; reset discards partial products immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      hilo_q <= '0;
      cnt_q  <= '0;
    end else begin
      hilo_q <= hilo_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.hilo_o = hilo_q;
  assign bus.cnt_o  = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
module tb_ex_mem;
  import ex_mem_pkg::*;

  localparam int OUT_W = REGADDR_W + 1 + DATA_W + 1 + DATA_W + DATA_W + 2*DATA_W + CNT_W;

  typedef struct {
    logic                 flush;
    logic [STALL_W-1:0]   stall;
    logic [REGADDR_W-1:0] wd;
    logic                 wreg;
    logic [DATA_W-1:0]    wdata;
    logic                 whilo;
    logic [DATA_W-1:0]    hi;
    logic [DATA_W-1:0]    lo;
    logic [2*DATA_W-1:0]  hilo;
    logic [CNT_W-1:0]     cnt;
    logic [OUT_W-1:0]     exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   illegal_seen;

  ex_mem_if bus ();

  ex_mem u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller should never stall mem while ex runs; report it when seen.
  always @(posedge clk) begin
    if (rst && !bus.stall[STALL_EX] && bus.stall[STALL_MEM]) begin
      illegal_seen++;
      $display("ASSERT illegal stall vector %b at %0t (ex running, mem stalled)", bus.stall, $time);
    end
  end

  function automatic logic [OUT_W-1:0] pk(input logic [REGADDR_W-1:0] wd, input logic wreg,
                                         input logic [DATA_W-1:0] wdata, input logic whilo,
                                         input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo,
                                         input logic [2*DATA_W-1:0] hilo, input logic [CNT_W-1:0] cnt);
    return {wd, wreg, wdata, whilo, hi, lo, hilo, cnt};
  endfunction

  function automatic logic [OUT_W-1:0] dut_out();
    return pk(bus.mem_wd, bus.mem_wreg, bus.mem_wdata, bus.mem_whilo,
              bus.mem_hi, bus.mem_lo, bus.hilo_o, bus.cnt_o);
  endfunction

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic flush, input logic [STALL_W-1:0] stall,
                       input logic [REGADDR_W-1:0] wd, input logic wreg,
                       input logic [DATA_W-1:0] wdata, input logic whilo,
                       input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo,
                       input logic [2*DATA_W-1:0] hilo, input logic [CNT_W-1:0] cnt);
    bus.flush    = flush;
    bus.stall    = stall;
    bus.ex_wd    = wd;
    bus.ex_wreg  = wreg;
    bus.ex_wdata = wdata;
    bus.ex_whilo = whilo;
    bus.ex_hi    = hi;
    bus.ex_lo    = lo;
    bus.hilo_i   = hilo;
    bus.cnt_i    = cnt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic flush, input logic [STALL_W-1:0] stall,
                              input logic [REGADDR_W-1:0] wd, input logic wreg,
                              input logic [DATA_W-1:0] wdata, input logic whilo,
                              input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo,
                              input logic [2*DATA_W-1:0] hilo, input logic [CNT_W-1:0] cnt,
                              input logic [OUT_W-1:0] exp);
    vec_t v;
    v.flush = flush; v.stall = stall; v.wd = wd; v.wreg = wreg; v.wdata = wdata;
    v.whilo = whilo; v.hi = hi; v.lo = lo; v.hilo = hilo; v.cnt = cnt; v.exp = exp;
    return v;
  endfunction

  // Reference: what the memory stage and the accumulator should see after one edge.
  function automatic logic [OUT_W-1:0] model(input logic [OUT_W-1:0] cur, input logic flush,
                                            input logic [STALL_W-1:0] stall,
                                            input logic [REGADDR_W-1:0] wd, input logic wreg,
                                            input logic [DATA_W-1:0] wdata, input logic whilo,
                                            input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo,
                                            input logic [2*DATA_W-1:0] hilo, input logic [CNT_W-1:0] cnt);
    if (flush) return '0;
    if (stall[3] == 1'b0) return pk(wd, wreg, wdata, whilo, hi, lo, '0, '0);
    if (stall[4] == 1'b0) return pk('0, 1'b0, '0, 1'b0, '0, '0, hilo, cnt);
    return cur;
  endfunction

  vec_t             tbl[11];
  logic [OUT_W-1:0] saved;
  logic [OUT_W-1:0] m_out;

  initial begin
    n_checks = 0;
    n_fail = 0;
    illegal_seen = 0;
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, '0, '0);
    #12;
    check("reset_state", dut_out(), '0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Build non-zero state, then assert reset mid-cycle.
    drive(1'b0, 6'b000000, 5'd17, 1'b1, 32'hFFFF_0001, 1'b1, 32'h1, 32'h2, '0, '0);
    step();
    drive(1'b0, 6'b001111, 5'd17, 1'b1, 32'hFFFF_0001, 1'b1, 32'h1, 32'h2, 64'h77, 2'd3);
    step();
    check("pre_reset_nonzero", {(dut_out() != '0)}, {{(OUT_W-1){1'b0}}, 1'b1});
    #2; rst = 1'b0; #1;
    check("async_reset_immediate", dut_out(), '0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 6'b000000, 5'd5, 1'b1, 32'h1234, 1'b0, '0, '0, '0, '0);
    step();
    check("after_reset_advance", dut_out(), pk(5'd5, 1'b1, 32'h1234, 1'b0, '0, '0, '0, '0));

    // Directed table; expectations worked out by hand, state starts from row above.
    tbl[0]  = mk(0, 6'b000000, 5'd5,  1, 32'h1234, 0, 0, 0, 64'h55, 3,
                 pk(5'd5, 1, 32'h1234, 0, 0, 0, 0, 0));
    tbl[1]  = mk(0, 6'b000000, 5'd0,  0, 32'h0, 1, 32'hDEAD0000, 32'h0000BEEF, 0, 0,
                 pk(5'd0, 0, 32'h0, 1, 32'hDEAD0000, 32'h0000BEEF, 0, 0));
    tbl[2]  = mk(0, 6'b001111, 5'd7,  1, 32'h99, 1, 1, 1, 64'h00000001_00000002, 1,
                 pk(0, 0, 0, 0, 0, 0, 64'h00000001_00000002, 1));
    tbl[3]  = mk(0, 6'b000000, 5'd9,  1, 32'h77, 0, 0, 0, 64'h3, 2,
                 pk(5'd9, 1, 32'h77, 0, 0, 0, 0, 0));
    tbl[4]  = mk(0, 6'b011111, 5'd3,  0, 32'hFFFF, 1, 5, 6, 64'h8, 1,
                 pk(5'd9, 1, 32'h77, 0, 0, 0, 0, 0));
    tbl[5]  = mk(0, 6'b001111, 5'd2,  1, 32'h44, 1, 3, 4, 64'hAB, 2,
                 pk(0, 0, 0, 0, 0, 0, 64'hAB, 2));
    tbl[6]  = mk(0, 6'b011111, 5'd2,  1, 32'h44, 1, 3, 4, 64'hCD, 3,
                 pk(0, 0, 0, 0, 0, 0, 64'hAB, 2));
    tbl[7]  = mk(0, 6'b000000, 5'd4,  1, 32'h5, 1, 1, 2, 64'hEE, 1,
                 pk(5'd4, 1, 32'h5, 1, 1, 2, 0, 0));
    tbl[8]  = mk(1, 6'b001111, 5'd6,  1, 32'h8, 1, 9, 9, 64'hFF, 3,
                 pk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl[9]  = mk(0, 6'b000000, 5'h1F, 0, 32'hCAFE, 0, 0, 0, 64'h1, 1,
                 pk(5'h1F, 0, 32'hCAFE, 0, 0, 0, 0, 0));
    tbl[10] = mk(1, 6'b011111, 5'd1,  1, 32'h1, 1, 1, 1, 64'h1, 1,
                 pk(0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].flush, tbl[i].stall, tbl[i].wd, tbl[i].wreg, tbl[i].wdata,
            tbl[i].whilo, tbl[i].hi, tbl[i].lo, tbl[i].hilo, tbl[i].cnt);
      step();
      check($sformatf("table_row_%0d", i), dut_out(), tbl[i].exp);
    end

    // Bubble building accumulator state, then hold for three cycles with noisy inputs.
    drive(0, 6'b001111, 5'd8, 1, 32'h10, 1, 2, 3, 64'h12345678_9ABCDEF0, 2'd2);
    step();
    saved = pk(0, 0, 0, 0, 0, 0, 64'h12345678_9ABCDEF0, 2'd2);
    check("bubble_acc", dut_out(), saved);
    for (int i = 0; i < 3; i++) begin
      drive(0, 6'b011111, 5'($urandom), 1'($urandom), $urandom, 1'($urandom),
            $urandom, $urandom, {$urandom, $urandom}, 2'($urandom));
      step();
      check($sformatf("hold_cycle_%0d", i), dut_out(), saved);
    end

    // Illegal controller combination: register still advances.
    drive(0, 6'b010000, 5'd12, 1, 32'hA5A5A5A5, 0, 0, 0, 64'h9, 1);
    step();
    check("illegal_stall_advance", dut_out(), pk(5'd12, 1, 32'hA5A5A5A5, 0, 0, 0, 0, 0));

    // Randomised run against the reference model, with prefix-shaped stall vectors.
    m_out = dut_out();
    for (int i = 0; i < 400; i++) begin
      logic                 f;
      logic [STALL_W-1:0]   s;
      logic [REGADDR_W-1:0] wd;
      logic                 wr;
      logic [DATA_W-1:0]    wdat;
      logic                 wh;
      logic [DATA_W-1:0]    hi;
      logic [DATA_W-1:0]    lo;
      logic [2*DATA_W-1:0]  hl;
      logic [CNT_W-1:0]     c;
      int                   depth;
      f     = ($urandom_range(0, 15) == 0);
      depth = $urandom_range(0, 6);
      s     = 6'((7'd1 << depth) - 7'd1);
      wd    = 5'($urandom);
      wr    = 1'($urandom);
      wdat  = $urandom;
      wh    = 1'($urandom);
      hi    = $urandom;
      lo    = $urandom;
      hl    = {$urandom, $urandom};
      c     = 2'($urandom);
      drive(f, s, wd, wr, wdat, wh, hi, lo, hl, c);
      m_out = model(m_out, f, s, wd, wr, wdat, wh, hi, lo, hl, c);
      step();
      check($sformatf("random_%0d", i), dut_out(), m_out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core.
- Captures the execute result: write-back address, enable and data, plus the HI/LO write request.
- Applies the pipeline controller's stall vector and flush: holds, inserts a bubble, or clears.
- Keeps the multi-cycle accumulator state (hilo_temp, cnt) that the execute stage needs across stall cycles of MADD/MSUB.

Parameters:
DATA_W, 32, width of a data word
REGADDR_W, 5, width of a register-file address
STALL_W, 6, width of stall vector (pc, if, id, ex, mem, wb)
CNT_W, 2, width of multi-cycle step counter

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-low
stall  in  STALL_W  stall request per stage; bit 3 = ex, bit 4 = mem
flush  in  1  exception flush, clears the register
ex_wd  in  REGADDR_W  destination register from execute
ex_wreg  in  1  register write enable from execute
ex_wdata  in  DATA_W  result from execute
ex_whilo  in  1  HI/LO write enable from execute
ex_hi  in  DATA_W  HI value from execute
ex_lo  in  DATA_W  LO value from execute
hilo_i  in  2*DATA_W  partial product from execute (multi-cycle)
cnt_i  in  CNT_W  step count from execute (multi-cycle)
mem_wd  out  REGADDR_W  destination register to memory stage
mem_wreg  out  1  write enable to memory stage
mem_wdata  out  DATA_W  data to memory stage
mem_whilo  out  1  HI/LO write enable to memory stage
mem_hi  out  DATA_W  HI to memory stage
mem_lo  out  DATA_W  LO to memory stage
hilo_o  out  2*DATA_W  held partial product back to execute
cnt_o  out  CNT_W  held step count back to execute

Behaviour:
- All outputs are registers, updated on rising clk; one-cycle latency from ex_* to mem_*.
- Reset (rst=0, asynchronous):
  - mem_wd = 0 (NOP register), mem_wreg = 0, mem_wdata = 0.
  - mem_whilo = 0, mem_hi = 0, mem_lo = 0.
  - hilo_o = 0, cnt_o = 0.
  - Reset asserted mid-operation discards in-flight data and accumulator state immediately, without waiting for a clock edge.
- Per-edge priority, highest first:
  1. flush=1: all mem_* outputs cleared to reset values; hilo_o=0; cnt_o=0. Flush overrides any stall.
  2. stall[3]=1 and stall[4]=0 (ex stalled, mem free), bubble:
     - mem_* cleared to reset values, so no write-back and no HI/LO write.
     - hilo_o <= hilo_i; cnt_o <= cnt_i (accumulator advances).
  3. stall[3]=0, normal advance:
     - mem_* <= ex_* (all six fields).
     - hilo_o <= 0; cnt_o <= 0.
  4. stall[3]=1 and stall[4]=1, hold: all outputs keep their values.
- stall[3]=0 with stall[4]=1 is illegal from the controller. The required behaviour is advance (case 3); the bench flags it as an assertion.
- mem_wreg=0 does not mask mem_wd/mem_wdata during advance; they pass through unchanged.
- No arithmetic; widths pass through unmodified.
- cnt_o holds its value and does not wrap; the execute stage owns the sequencing.

Decomposition:
- Shared package/defines:
  - ZEROWORD, NOPREGADDR, width constants (DATA_W, REGADDR_W, CNT_W).
  - Stall bit indices STALL_EX=3, STALL_MEM=4.
  - Reset-active level constant (0).
- Optional sub-module: pipe_ctl_reg, a generic width-parameterised register implementing the flush / bubble / advance / hold decode. It is reusable by if_id, id_ex and mem_wb.
- The accumulator pair stays inline.

Test Plan:
- Reset: rst=0 mid-cycle while outputs hold non-zero values -> all outputs 0 immediately, before the next edge; after release with stall=0, ex_wd=5, ex_wreg=1, ex_wdata=0x1234 -> after 1 edge mem_wd=5, mem_wreg=1, mem_wdata=0x1234.
- Pass-through: ex_whilo=1, ex_hi=0xDEAD0000, ex_lo=0x0000BEEF, stall=0 -> next edge mem_whilo=1, mem_hi=0xDEAD0000, mem_lo=0x0000BEEF; hilo_o=0, cnt_o=0.
- Bubble with accumulator: stall=6'b001111, hilo_i=0x00000001_00000002, cnt_i=1, ex_wreg=1 -> mem_wreg=0, mem_wd=0, mem_wdata=0; hilo_o=0x00000001_00000002, cnt_o=1. Next edge with stall=0, cnt_i=2 -> cnt_o=0, mem_* = ex_*.
- Hold: stall=6'b011111 for 3 cycles while ex_* toggles randomly -> all outputs unchanged from the prior edge.
- Flush priority: flush=1 with stall=6'b001111 and mem_wreg=1 previously -> next edge all outputs 0.
- Illegal stall: stall=6'b010000, ex_wdata=0xA5A5A5A5 -> mem_wdata=0xA5A5A5A5 and the bench assertion fires.
